// File: rtl/aes_key_expand_if.sv
// Signal bundle for the AES-128 key expander: the control/status handshake,
// the round-key read port and the shared serial S-box request/response bus.
// slave = key expander side, master = controller / S-box / consumer side.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_ready;
    logic         sbox_req;
    logic [7:0]   sbox_addr;
    logic [7:0]   sbox_out;
    logic         sbox_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    modport slave (
        input  start, key_in, sbox_out, sbox_valid, rk_idx,
        output busy, done, keys_ready, sbox_req, sbox_addr, rk_out
    );

    modport master (
        output start, key_in, sbox_out, sbox_valid, rk_idx,
        input  busy, done, keys_ready, sbox_req, sbox_addr, rk_out
    );
endinterface

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule. Expands key_in into rk[0..10] using the
// shared serial S-box for SubWord (one byte in flight at a time) and holds
// the round keys in a register file behind a combinational read mux.
module aes_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input logic             clk,
    input logic             reset_n,
    aes_key_expand_if.slave bus
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_XOR
    } state_t;

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         keys_ready_q, keys_ready_d;
    logic         sbox_req_q, sbox_req_d;
    logic [7:0]   sbox_addr_q, sbox_addr_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [1:0]   byte_q, byte_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  temp_q, temp_d;
    logic [31:0]  w_q [4];
    logic [31:0]  w_d [4];
    logic [127:0] rk_q [NUM_ROUNDS+1];
    logic [127:0] rk_d [NUM_ROUNDS+1];

    logic [31:0]  xor_t;
    logic [31:0]  nw0, nw1, nw2, nw3;

    // Byte j of RotWord(w), MSB first.
    function automatic logic [7:0] rot_byte(input logic [31:0] w, input logic [1:0] j);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        case (j)
            2'd0:    return r[31:24];
            2'd1:    return r[23:16];
            2'd2:    return r[15:8];
            default: return r[7:0];
        endcase
    endfunction

    // Next working words of a round from the collected SubWord bytes.
    always_comb begin
        xor_t = temp_q ^ {rcon_q, 24'h0};
        nw0   = w_q[0] ^ xor_t;
        nw1   = w_q[1] ^ nw0;
        nw2   = w_q[2] ^ nw1;
        nw3   = w_q[3] ^ nw2;
    end

    // Next-state and next-output logic for the expansion FSM.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_ready_d = keys_ready_q;
        sbox_req_d   = 1'b0;
        sbox_addr_d  = sbox_addr_q;
        rcon_d       = rcon_q;
        byte_d       = byte_q;
        round_d      = round_q;
        temp_d       = temp_q;
        w_d          = w_q;
        rk_d         = rk_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rk_d[0]      = bus.key_in;
                    w_d[0]       = bus.key_in[127:96];
                    w_d[1]       = bus.key_in[95:64];
                    w_d[2]       = bus.key_in[63:32];
                    w_d[3]       = bus.key_in[31:0];
                    rcon_d       = RCON_INIT;
                    round_d      = 4'd1;
                    byte_d       = 2'd0;
                    busy_d       = 1'b1;
                    keys_ready_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.sbox_valid) begin
                    case (byte_q)
                        2'd0:    temp_d[31:24] = bus.sbox_out;
                        2'd1:    temp_d[23:16] = bus.sbox_out;
                        2'd2:    temp_d[15:8]  = bus.sbox_out;
                        default: temp_d[7:0]   = bus.sbox_out;
                    endcase
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_XOR;
                    end
                end
            end
            S_XOR: begin
                rk_d[round_q] = {nw0, nw1, nw2, nw3};
                w_d[0]        = nw0;
                w_d[1]        = nw1;
                w_d[2]        = nw2;
                w_d[3]        = nw3;
                rcon_d        = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (round_q < LAST_ROUND) begin
                    round_d = round_q + 4'd1;
                    byte_d  = 2'd0;
                    state_d = S_REQ;
                end else begin
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    keys_ready_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request is registered, so it is raised on the edge that enters REQ,
        // addressed from the word/byte that REQ will be working on.
        if (state_d == S_REQ) begin
            sbox_req_d  = 1'b1;
            sbox_addr_d = rot_byte(w_d[3], byte_d);
        end
    end

    // State and register-file update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            sbox_req_q   <= 1'b0;
            sbox_addr_q  <= '0;
            rcon_q       <= RCON_INIT;
            byte_q       <= '0;
            round_q      <= '0;
            temp_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                w_q[i] <= '0;
            end
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_ready_q <= keys_ready_d;
            sbox_req_q   <= sbox_req_d;
            sbox_addr_q  <= sbox_addr_d;
            rcon_q       <= rcon_d;
            byte_q       <= byte_d;
            round_q      <= round_d;
            temp_q       <= temp_d;
            w_q          <= w_d;
            rk_q         <= rk_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.sbox_req   = sbox_req_q;
    assign bus.sbox_addr  = sbox_addr_q;

    // Round-key read mux; out-of-range selects read as zero.
    always_comb begin
        bus.rk_out = '0;
        if (bus.rk_idx <= LAST_ROUND) begin
            bus.rk_out = rk_q[bus.rk_idx];
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key vectors, a
// behavioural shared S-box with fixed or random latency, restart-while-busy,
// mid-run reset and back-to-back start in the done cycle.
module tb_aes_key_expand;
    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO  = 128'h0;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_lat = 1'b0;
    int   req_count = 0;
    int   overlap_count = 0;

    always #5 clk = ~clk;

    aes_key_expand_if kif ();

    aes_key_expand #(
        .NUM_ROUNDS (10),
        .RCON_INIT  (8'h01)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (kif.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Shared S-box model: request seen mid-cycle, response pulse L cycles later.
    initial begin
        int         cnt;
        logic [7:0] addr_l;
        cnt            = 0;
        addr_l         = 8'h00;
        kif.sbox_valid = 1'b0;
        kif.sbox_out   = 8'h00;
        forever begin
            @(negedge clk);
            kif.sbox_valid = 1'b0;
            if (!reset_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        kif.sbox_valid = 1'b1;
                        kif.sbox_out   = sbox(addr_l);
                    end
                end
                if (kif.sbox_req) begin
                    if (cnt != 0) overlap_count++;
                    req_count++;
                    addr_l = kif.sbox_addr;
                    cnt    = rand_lat ? int'($urandom_range(1, 6)) : 1;
                end
            end
        end
    end

    task automatic check_rk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        kif.rk_idx = idx;
        #1;
        check(tag, kif.rk_out, exp);
    endtask

    // Caller has just raised start at a negedge. Returns the number of
    // negedges until done is seen (-1 on timeout). At restart_at a second
    // start with a different key is pulsed.
    task automatic wait_done(input int restart_at, output int k_done);
        k_done = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) kif.start = 1'b0;
            if (k == restart_at) begin
                kif.start  = 1'b1;
                kif.key_in = ~kif.key_in;
            end
            if (k == restart_at + 1) kif.start = 1'b0;
            if (kif.done) begin
                k_done = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (kif.done) c++;
        end
    endtask

    task automatic begin_run(input logic [127:0] key);
        kif.key_in = key;
        kif.start  = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int c;
        reset_n    = 1'b0;
        kif.start  = 1'b0;
        kif.key_in = '0;
        kif.rk_idx = 4'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 128'(kif.busy), 128'd0);
        check("rst_done", 128'(kif.done), 128'd0);
        check("rst_keys_ready", 128'(kif.keys_ready), 128'd0);
        check("rst_sbox_req", 128'(kif.sbox_req), 128'd0);
        check("rst_sbox_addr", 128'(kif.sbox_addr), 128'd0);
        check_rk("rst_rk0", 4'd0, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 key, L=1
        req_count = 0;
        begin_run(KEY_FIPS);
        wait_done(0, k);
        check("s1_latency", 128'(k - 1), 128'd90);
        check("s1_keys_ready", 128'(kif.keys_ready), 128'd1);
        check("s1_busy", 128'(kif.busy), 128'd0);
        check("s1_req_count", 128'(req_count), 128'd40);
        check_rk("s1_rk0", 4'd0, KEY_FIPS);
        check_rk("s1_rk1", 4'd1, FIPS_RK1);
        check_rk("s1_rk10", 4'd10, FIPS_RK10);

        // 2: all-zero key, out-of-range read selects
        @(negedge clk);
        begin_run(KEY_ZERO);
        wait_done(0, k);
        check("s2_latency", 128'(k - 1), 128'd90);
        check_rk("s2_rk1", 4'd1, ZERO_RK1);
        check_rk("s2_rk10", 4'd10, ZERO_RK10);
        for (int i = 11; i < 16; i++) begin
            check_rk($sformatf("s2_rk_oob%0d", i), 4'(i), 128'd0);
        end

        // 3: random S-box latency
        @(negedge clk);
        rand_lat      = 1'b1;
        req_count     = 0;
        overlap_count = 0;
        begin_run(KEY_FIPS);
        wait_done(0, k);
        rand_lat = 1'b0;
        check("s3_done_seen", 128'(k > 0), 128'd1);
        check("s3_req_count", 128'(req_count), 128'd40);
        check("s3_no_overlap", 128'(overlap_count), 128'd0);
        check_rk("s3_rk1", 4'd1, FIPS_RK1);
        check_rk("s3_rk10", 4'd10, FIPS_RK10);

        // 5: reset at cycle 45, then restart with zero key
        @(negedge clk);
        begin_run(KEY_FIPS);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) kif.start = 1'b0;
        end
        check("s5_busy_before", 128'(kif.busy), 128'd1);
        reset_n = 1'b0;
        #1;
        check("s5_busy", 128'(kif.busy), 128'd0);
        check("s5_keys_ready", 128'(kif.keys_ready), 128'd0);
        check("s5_sbox_req", 128'(kif.sbox_req), 128'd0);
        check_rk("s5_rk1_cleared", 4'd1, 128'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        begin_run(KEY_ZERO);
        wait_done(0, k);
        check("s5_latency", 128'(k - 1), 128'd90);
        check_rk("s5_rk1", 4'd1, ZERO_RK1);
        check_rk("s5_rk10", 4'd10, ZERO_RK10);

        // 4: start pulsed again (different key) at cycle 30 is ignored
        @(negedge clk);
        begin_run(KEY_FIPS);
        wait_done(30, k);
        check("s4_latency", 128'(k - 1), 128'd90);
        count_done(20, c);
        check("s4_extra_done", 128'(c), 128'd0);
        check_rk("s4_rk0", 4'd0, KEY_FIPS);
        check_rk("s4_rk1", 4'd1, FIPS_RK1);
        check_rk("s4_rk10", 4'd10, FIPS_RK10);

        // 6: back-to-back start in the done cycle
        @(negedge clk);
        begin_run(KEY_ZERO);
        wait_done(0, k);
        check("s6_first_latency", 128'(k - 1), 128'd90);
        check("s6_ready_in_done", 128'(kif.keys_ready), 128'd1);
        begin_run(KEY_FIPS);
        @(negedge clk);
        kif.start = 1'b0;
        check("s6_ready_dropped", 128'(kif.keys_ready), 128'd0);
        check("s6_busy", 128'(kif.busy), 128'd1);
        wait_done(0, k);
        check("s6_second_latency", 128'(k), 128'd90);
        check("s6_ready_again", 128'(kif.keys_ready), 128'd1);
        check_rk("s6_rk1", 4'd1, FIPS_RK1);
        check_rk("s6_rk10", 4'd10, FIPS_RK10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Sequential AES-128 key schedule.
- Expands a 128-bit cipher key into 11 round keys (rk[0]..rk[10]) and holds them in an internal register file.
- Exposes a combinational read port so the round function stage can take its round_key from rk_out.
- Has no S-box of its own. It performs SubWord through the shared serial S-box interface (sbox_req/sbox_addr out, sbox_out/sbox_valid in), the same S-box the round datapath uses.

Parameters:
NUM_ROUNDS  10  number of round keys generated after rk[0]; only 10 supported (AES-128)
RCON_INIT  8'h01  Rcon value used for round 1

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  pulse; begin expansion of key_in (accepted only in IDLE)
key_in  input  128  cipher key; key_in[127:96]=w0 ... key_in[31:0]=w3, byte 0 = MSB
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when rk[10] has been written
keys_ready  output  1  high while all 11 round keys are valid
sbox_req  output  1  one-cycle request pulse to the shared S-box
sbox_addr  output  8  S-box lookup byte, valid while sbox_req=1
sbox_out  input  8  S-box result, valid when sbox_valid=1
sbox_valid  input  1  one-cycle response pulse, L>=1 cycles after sbox_req
rk_idx  input  4  round key select, 0..10
rk_out  output  128  rk[rk_idx], combinational; 0 if rk_idx>10

Behaviour:
- Reset (async): FSM=IDLE, busy=0, done=0, keys_ready=0, sbox_req=0, sbox_addr=0, rcon=RCON_INIT, byte counter=0, round counter=0, all rk entries=0.
- FSM states: IDLE, REQ, WAIT, XOR.
- IDLE:
  - start=1 at edge E0 → rk[0]<=key_in, working words w0..w3<=key_in, rcon<=RCON_INIT, round=1, byte=0, busy<=1, keys_ready<=0; go to REQ.
  - start=0 → stay in IDLE.
- REQ: drive sbox_req=1 for exactly one cycle with sbox_addr = byte j of RotWord(w3), j=byte counter. RotWord(w3) = {w3[23:0], w3[31:24]}; byte j = bits [31-8j -: 8]. Go to WAIT.
- WAIT:
  - Hold until sbox_valid=1.
  - On valid: store sbox_out into temp byte j.
  - j<3: j++, go to REQ.
  - j=3: go to XOR.
  - sbox_req stays 0 throughout WAIT.
- XOR (one cycle):
  - t = {temp0,temp1,temp2,temp3} ^ {rcon,24'h0}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
  - rk[round]<={w0',w1',w2',w3'}; working words updated.
  - rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - round<NUM_ROUNDS: round++, j=0, go to REQ.
  - Else: done<=1 (one cycle), busy<=0, keys_ready<=1, go to IDLE.
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- Latency with S-box latency L:
  - Each byte costs L+1 cycles (request cycle plus wait); each round costs 4(L+1)+1 cycles.
  - L=1: rk[r] written at E0+9r; done high in the cycle after E0+90.
- Boundary conditions:
  - start while busy: ignored, expansion continues unaffected.
  - start in the cycle done is high: FSM is already in IDLE, so start is accepted.
  - sbox_valid outside WAIT: ignored.
  - At most one outstanding S-box request at any time.
  - New start: keys_ready drops on the acceptance edge; rk[1..10] keep stale values until overwritten, so consumers must gate on keys_ready.
  - reset_n low mid-expansion: immediate return to reset state; any pending S-box response is discarded.
- rk_out is a pure mux of the register file, with no added latency.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, S-box model with L=1 → rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses exactly 90 cycles after the start edge; keys_ready=1 afterwards.
2. All-zero key → rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e; rk_idx=11..15 → rk_out=0.
3. Random S-box latency 1..6 with the FIPS key → same rk values; sbox_req is never asserted while a request is outstanding; exactly 40 requests total.
4. Pulse start again at cycle 30 of an expansion → ignored; results identical to scenario 1; single done pulse.
5. Assert reset_n low at cycle 45 of an expansion, then release and restart with the zero key → busy/keys_ready/sbox_req go to 0 immediately; second run gives the scenario-2 keys.
6. Back-to-back: start asserted in the done cycle with a new key → accepted; keys_ready falls on that edge, then rises with the new rk set.
